uart_tx_block_sched: RTL

- Sequences one 16-byte block (the 128-bit AES ciphertext) through the 8-bit UART transmitter, one byte at a time.
- Accepts a block with a valid/ready handshake and drives the transmitter's start/in/en inputs.
- Tracks each byte through the transmitter's busy/done outputs.
- Inserts a configurable idle gap between bytes and aborts on a stuck transmitter via a watchdog.
- Sits between the AES core output and the UART transmitter, clocked in the baud-rate domain.

---
 rtl/uart_tx_block_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_block_sched.sv
// Sends a NUM_BYTES block to a byte-wide UART transmitter, top byte first, with an idle gap and a watchdog.
// Outputs registered; first tx_start one clock after capture; blk_ready stays low until one clock after blk_sent.
module uart_tx_block_sched #(
  parameter int NUM_BYTES  = 16,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [8*NUM_BYTES-1:0]       blk_data,
  input  logic                         blk_valid,
  output logic                         blk_ready,
  output logic                         tx_en,
  output logic                         tx_start,
  output logic [7:0]                   tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic                         blk_sent,
  output logic                         sched_busy,
  output logic [$clog2(NUM_BYTES)-1:0] byte_idx,
  output logic                         err_timeout,
  input  logic                         err_clr
);

  localparam int IW = $clog2(NUM_BYTES);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [8*NUM_BYTES-1:0] hold_q, hold_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic [IW-1:0]          idx_d;
  logic [7:0]             tx_data_d;
  logic                   timeout, last_done, err_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    idx_d     = byte_idx;
    timeout   = 1'b0;
    last_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (blk_valid && blk_ready) begin
          hold_d  = blk_data;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_busy) state_d = WAIT_DONE;
        else if (wd_q == WD_LAST) timeout = 1'b1;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (byte_idx == LAST_IDX) begin
            last_done = 1'b1;
            state_d   = IDLE;
          end else begin
            // The holding register shifts so the next byte always sits at the top.
            idx_d   = byte_idx + 1'b1;
            hold_d  = hold_q << 8;
            state_d = (GAP_CYCLES == 0) ? ISSUE : GAP;
          end
        end else if (wd_q == WD_LAST) begin
          timeout = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = ISSUE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) state_d = IDLE;
    if (state_d == IDLE) idx_d = '0;
    if (state_d == GAP && state_q != GAP) gap_d = '0;

    // Watchdog only runs while a byte is being offered or is on the wire.
    if ((state_d == ISSUE || state_d == WAIT_DONE) && state_d == state_q) wd_d = wd_q + 1'b1;
    else wd_d = '0;

    tx_data_d = (state_d == ISSUE && state_q != ISSUE) ? hold_d[8*NUM_BYTES-1 -: 8] : tx_data;
    err_d     = timeout | (err_timeout & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      gap_q       <= '0;
      wd_q        <= '0;
      blk_ready   <= 1'b1;
      tx_en       <= 1'b1;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      blk_sent    <= 1'b0;
      sched_busy  <= 1'b0;
      byte_idx    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      wd_q        <= wd_d;
      // The blk_sent clock is an enforced IDLE bubble before the next block.
      blk_ready   <= (state_d == IDLE) && !last_done;
      tx_en       <= 1'b1;
      tx_start    <= (state_d == ISSUE);
      tx_data     <= tx_data_d;
      blk_sent    <= last_done;
      sched_busy  <= (state_d != IDLE);
      byte_idx    <= idx_d;
      err_timeout <= err_d;
    end
  end

endmodule
